// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader: periodic 3-wire SPI temperature read with valid strobe and hysteretic fan request
// Ports: OSC_50_B3B/RESET_n clock and async active-low reset; start on-demand request;
//        TEMP_CS_n/TEMP_SCLK/TEMP_DIN/TEMP_DOUT sensor pins; temp_data/temp_valid last good reading;
//        frame_err rejected-frame pulse; busy transfer in progress; fan_on fan request.
module temp_sensor_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000000,
  parameter int FAN_ON_TEMP   = 1280,
  parameter int FAN_OFF_TEMP  = 1120
) (
  input  logic        OSC_50_B3B,
  input  logic        RESET_n,
  input  logic        start,
  input  logic        TEMP_DOUT,
  output logic        TEMP_CS_n,
  output logic        TEMP_SCLK,
  output logic        TEMP_DIN,
  output logic [13:0] temp_data,
  output logic        temp_valid,
  output logic        frame_err,
  output logic        busy,
  output logic        fan_on
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic signed [13:0] ON_T  = 14'(FAN_ON_TEMP);
  localparam logic signed [13:0] OFF_T = 14'(FAN_OFF_TEMP);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, SHIFT = 3'd2, HOLD = 3'd3, GAP = 3'd4, DONE = 3'd5;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic [3:0]    bit_idx;
  logic [15:0]   frame;
  logic          pending;
  logic          trig, go, last;
  logic signed [13:0] value;
  assign TEMP_DIN = 1'b0;
  assign trig  = start || cnt == '0;
  // IDLE accepts a trigger in the same cycle it arrives, so the first
  // transfer starts on the first clock after reset release
  assign go    = pending || trig;
  assign last  = div == DIV_MAX;
  assign value = frame[13:0];
  always_ff @(posedge OSC_50_B3B or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= IDLE;
      cnt        <= '0;
      div        <= '0;
      bit_idx    <= '0;
      frame      <= '0;
      pending    <= 1'b0;
      TEMP_CS_n  <= 1'b1;
      TEMP_SCLK  <= 1'b1;
      temp_data  <= '0;
      temp_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      fan_on     <= 1'b1;
    end else begin
      cnt        <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
      // triggers outside IDLE merge into one request
      pending    <= state != IDLE && (pending || trig);
      temp_valid <= 1'b0;
      frame_err  <= 1'b0;
      div        <= last ? '0 : div + 1'b1;
      case (state)
        IDLE: begin
          div <= '0;
          if (go) begin
            state     <= SETUP;
            busy      <= 1'b1;
            TEMP_CS_n <= 1'b0;
          end
        end
        SETUP: if (last) begin
          state     <= SHIFT;
          bit_idx   <= 4'd15;
          TEMP_SCLK <= 1'b0;
        end
        SHIFT: if (last) begin
          if (!TEMP_SCLK) begin
            TEMP_SCLK <= 1'b1;
            frame     <= {frame[14:0], TEMP_DOUT};
          end else if (bit_idx == 4'd0) begin
            state <= HOLD;
          end else begin
            TEMP_SCLK <= 1'b0;
            bit_idx   <= bit_idx - 1'b1;
          end
        end
        HOLD: if (last) begin
          state     <= GAP;
          TEMP_CS_n <= 1'b1;
        end
        // publishing on the GAP exit makes the pulses coincide with the DONE cycle
        GAP: if (last) begin
          state <= DONE;
          if (frame[15:14] == 2'b00) begin
            temp_data  <= frame[13:0];
            temp_valid <= 1'b1;
            fan_on     <= value >= ON_T ? 1'b1 : value < OFF_T ? 1'b0 : fan_on;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb_temp_sensor_reader: directed bench with a behavioural SPI sensor model
module tb_temp_sensor_reader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, dout = 1'b0;
  logic        cs_n, sclk, din, tv, fe, busy, fan;
  logic [13:0] data;
  logic [15:0] word = 16'h0500;
  int          idx = 15;
  int          checks = 0, errors = 0;
  temp_sensor_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(400)) dut (
    .OSC_50_B3B(clk), .RESET_n(rst_n), .start(start), .TEMP_DOUT(dout),
    .TEMP_CS_n(cs_n), .TEMP_SCLK(sclk), .TEMP_DIN(din), .temp_data(data),
    .temp_valid(tv), .frame_err(fe), .busy(busy), .fan_on(fan)
  );
  always #5 clk = ~clk;
  // sensor: MSB presented at CS fall, later bits shifted out on SCLK falling edges
  always @(negedge cs_n) begin
    idx = 15;
    dout = word[15];
  end
  always @(posedge sclk) if (cs_n == 1'b0) idx--;
  always @(negedge sclk) if (cs_n == 1'b0 && idx >= 0) dout = word[idx];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_res(input logic [15:0] w, input string tag);
    int n = 0;
    word = w;
    tick();
    while (!(tv || fe) && n < 1000) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, 32'(n < 1000), 1);
  endtask
  task automatic wait_busy(input logic level, input string tag);
    int n = 0;
    while (busy !== level && n < 1000) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 1000), 1);
  endtask
  initial begin
    int rises, r1, r2, vcnt, vcyc, extra, n;
    logic prev;
    repeat (3) tick();
    check("rst_cs", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_din", din, 0);
    check("rst_fan", fan, 1);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", tv, 0);
    rst_n = 1'b1;
    check("cs_before", cs_n, 1);
    rises = 0; r1 = 0; r2 = 0; vcnt = 0; vcyc = 0; prev = sclk;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 1) check("cs_fall", cs_n, 0);
      if (sclk && !prev) begin
        rises++;
        if (rises == 1) r1 = i;
        if (rises == 2) r2 = i;
      end
      prev = sclk;
      if (tv) begin
        vcnt++;
        vcyc = i;
      end
    end
    check("rises", rises, 16);
    check("sclk_period", r2 - r1, 4);
    check("valid_count", vcnt, 1);
    check("valid_cycle", vcyc, 71);
    check("first_data", data, 14'h0500);
    check("first_fan", fan, 1);
    wait_res(16'h0460, "h1");
    check("h1_data", data, 14'h0460);
    check("h1_fan", fan, 1);
    wait_res(16'h0400, "h2");
    check("h2_fan", fan, 0);
    wait_res(16'h0500, "h3");
    check("h3_fan", fan, 1);
    wait_res(16'h04FF, "h4");
    check("h4_data", data, 14'h04FF);
    check("h4_fan", fan, 1);
    wait_res(16'h3FE0, "neg");
    check("neg_valid", tv, 1);
    check("neg_err", fe, 0);
    check("neg_data", data, 14'h3FE0);
    check("neg_fan", fan, 0);
    wait_res(16'h8123, "ferr");
    check("ferr_err", fe, 1);
    check("ferr_valid", tv, 0);
    check("ferr_data", data, 14'h3FE0);
    check("ferr_fan", fan, 0);
    tick();
    check("ferr_width", fe, 0);
    word = 16'h0500;
    wait_busy(1'b1, "busy_rise");
    repeat (10) tick();
    repeat (3) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
    end
    wait_busy(1'b0, "busy_fall");
    tick();
    check("extra_cs", cs_n, 0);
    check("extra_busy", busy, 1);
    wait_busy(1'b0, "extra_fall");
    extra = 0;
    repeat (10) begin
      tick();
      if (busy) extra++;
    end
    check("no_third", extra, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_cs", cs_n, 0);
    wait_busy(1'b0, "idle_fall");
    word = 16'h0123;
    start = 1'b1;
    tick();
    start = 1'b0;
    rises = 0; n = 0; prev = sclk;
    while (rises < 7 && n < 200) begin
      tick();
      if (sclk && !prev) rises++;
      prev = sclk;
      n++;
    end
    check("mid_rises", rises, 7);
    rst_n = 1'b0;
    #1;
    check("abort_cs", cs_n, 1);
    check("abort_sclk", sclk, 1);
    check("abort_data", data, 0);
    check("abort_busy", busy, 0);
    vcnt = 0;
    repeat (3) begin
      tick();
      if (tv) vcnt++;
    end
    check("abort_valid", vcnt, 0);
    rst_n = 1'b1;
    tick();
    check("restart_cs", cs_n, 0);
    check("restart_data", data, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
